// File: rtl/score_keeper_pkg.sv
// Shared constants, state encoding and 7-seg lookup for the score/game-state stage.
package score_keeper_pkg;

    localparam int SCORE_DIGITS = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_OVER = 2'd2
    } state_t;

    // Active-low, bit order gfedcba.
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;

    function automatic logic [6:0] seg_pattern(input logic [3:0] bcd);
        case (bcd)
            4'd0:    seg_pattern = SEG_0;
            4'd1:    seg_pattern = SEG_1;
            4'd2:    seg_pattern = SEG_2;
            4'd3:    seg_pattern = SEG_3;
            4'd4:    seg_pattern = SEG_4;
            4'd5:    seg_pattern = SEG_5;
            4'd6:    seg_pattern = SEG_6;
            4'd7:    seg_pattern = SEG_7;
            4'd8:    seg_pattern = SEG_8;
            4'd9:    seg_pattern = SEG_9;
            default: seg_pattern = SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/score_keeper_bcd_to_seg.sv
// One BCD digit plus blank flag to an active-low 7-seg pattern; purely combinational.
// Non-decimal codes render blank so hex glyphs can never appear.
module bcd_to_seg
    import score_keeper_pkg::*;
(
    input  logic [3:0] bcd_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        if (!blank_i) begin
            seg_o = seg_pattern(bcd_i);
        end
    end

endmodule

// File: rtl/score_keeper.sv
// Game-state FSM, BCD score with prescaler, speed level, high score and registered 7-seg drive.
// All outputs come straight from registers; no combinational input-to-output paths.
module score_keeper
    import score_keeper_pkg::*;
#(
    parameter int DIGITS          = SCORE_DIGITS,
    parameter int TICKS_PER_POINT = 4,
    parameter int LEVEL_POINTS    = 100
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic                  tick_i,
    input  logic                  start_i,
    input  logic                  collide_i,
    input  logic                  show_hi_i,
    output logic [4*DIGITS-1:0]   score_o,
    output logic [4*DIGITS-1:0]   hiscore_o,
    output logic [7*DIGITS-1:0]   seg_o,
    output logic [3:0]            level_o,
    output logic                  running_o,
    output logic                  game_over_o
);

    localparam int PW = (TICKS_PER_POINT > 1) ? $clog2(TICKS_PER_POINT) : 1;
    localparam int LW = (LEVEL_POINTS > 1) ? $clog2(LEVEL_POINTS) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICKS_PER_POINT - 1);
    localparam logic [LW-1:0] PTS_LAST = LW'(LEVEL_POINTS - 1);
    localparam logic [7*DIGITS-1:0] SEG_RESET = {{(DIGITS-1){SEG_BLANK}}, SEG_0};

    state_t                state_q, state_d;
    logic [PW-1:0]         pre_q, pre_d;
    logic [LW-1:0]         pts_q, pts_d;
    logic [3:0]            level_q, level_d;
    logic [4*DIGITS-1:0]   score_q, score_d, hi_q, hi_d;
    logic [7*DIGITS-1:0]   seg_q, seg_d;

    logic [4*DIGITS-1:0]   score_inc, disp;
    logic [DIGITS-1:0]     blank;
    logic                  carry, score_max, score_gt, nz;

    // Ripple-carry BCD +1; score_max flags the all-nines hold point.
    always_comb begin
        carry     = 1'b1;
        score_max = 1'b1;
        score_inc = score_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (score_q[4*i +: 4] != 4'd9) begin
                score_max = 1'b0;
            end
            if (carry) begin
                if (score_q[4*i +: 4] == 4'd9) begin
                    score_inc[4*i +: 4] = 4'd0;
                end else begin
                    score_inc[4*i +: 4] = score_q[4*i +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
    end

    // Higher digits are visited last so the most significant difference decides.
    always_comb begin
        score_gt = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (score_q[4*i +: 4] > hi_q[4*i +: 4]) begin
                score_gt = 1'b1;
            end else if (score_q[4*i +: 4] < hi_q[4*i +: 4]) begin
                score_gt = 1'b0;
            end
        end
    end

    assign disp = show_hi_i ? hi_q : score_q;

    always_comb begin
        nz       = 1'b0;
        blank    = '0;
        for (int i = DIGITS - 1; i > 0; i--) begin
            nz       = nz | (disp[4*i +: 4] != 4'd0);
            blank[i] = !nz;
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_seg
        bcd_to_seg u_bcd_to_seg (
            .bcd_i   (disp[4*g +: 4]),
            .blank_i (blank[g]),
            .seg_o   (seg_d[7*g +: 7])
        );
    end

    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        pts_d   = pts_q;
        level_d = level_q;
        score_d = score_q;
        hi_d    = hi_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_RUN;
                    score_d = '0;
                    pre_d   = '0;
                    pts_d   = '0;
                end
            end
            ST_RUN: begin
                if (collide_i) begin
                    state_d = ST_OVER;
                end else if (tick_i) begin
                    if (pre_q == PRE_LAST) begin
                        pre_d = '0;
                        if (!score_max) begin
                            score_d = score_inc;
                            if (pts_q == PTS_LAST) begin
                                pts_d = '0;
                                if (level_q != 4'd15) begin
                                    level_d = level_q + 4'd1;
                                end
                            end else begin
                                pts_d = pts_q + LW'(1);
                            end
                        end
                    end else begin
                        pre_d = pre_q + PW'(1);
                    end
                end
            end
            ST_OVER: begin
                // Score is frozen here, so re-comparing every OVER cycle is harmless.
                if (score_gt) begin
                    hi_d = score_q;
                end
                if (start_i && !collide_i) begin
                    state_d = ST_RUN;
                    score_d = '0;
                    pre_d   = '0;
                    pts_d   = '0;
                    level_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            pre_q   <= '0;
            pts_q   <= '0;
            level_q <= '0;
            score_q <= '0;
            hi_q    <= '0;
            seg_q   <= SEG_RESET;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            pts_q   <= pts_d;
            level_q <= level_d;
            score_q <= score_d;
            hi_q    <= hi_d;
            seg_q   <= seg_d;
        end
    end

    assign score_o     = score_q;
    assign hiscore_o   = hi_q;
    assign seg_o       = seg_q;
    assign level_o     = level_q;
    assign running_o   = (state_q == ST_RUN);
    assign game_over_o = (state_q == ST_OVER);

endmodule

// File: tb/tb_score_keeper.sv
// Bench for score_keeper: a full-size instance and a 2-digit instance that reaches saturation quickly.
module tb_score_keeper;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tick = 1'b0, start = 1'b0, collide = 1'b0, show_hi = 1'b0;

    logic [23:0] score_a, hi_a;
    logic [41:0] seg_a;
    logic [3:0]  level_a;
    logic        run_a, over_a;
    logic [7:0]  score_b, hi_b;
    logic [13:0] seg_b;
    logic [3:0]  level_b;
    logic        run_b, over_b;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    score_keeper #(.DIGITS(6), .TICKS_PER_POINT(4), .LEVEL_POINTS(100)) dut (
        .clock_i(clk), .reset_i(rst), .tick_i(tick), .start_i(start),
        .collide_i(collide), .show_hi_i(show_hi),
        .score_o(score_a), .hiscore_o(hi_a), .seg_o(seg_a), .level_o(level_a),
        .running_o(run_a), .game_over_o(over_a)
    );

    score_keeper #(.DIGITS(2), .TICKS_PER_POINT(2), .LEVEL_POINTS(10)) dut_s (
        .clock_i(clk), .reset_i(rst), .tick_i(tick), .start_i(start),
        .collide_i(collide), .show_hi_i(show_hi),
        .score_o(score_b), .hiscore_o(hi_b), .seg_o(seg_b), .level_o(level_b),
        .running_o(run_b), .game_over_o(over_b)
    );

    // ---------------- reference model (decimal integers) ----------------
    localparam int ND  [2] = '{6, 2};
    localparam int TPP [2] = '{4, 2};
    localparam int LP  [2] = '{100, 10};

    int m_state[2], m_score[2], m_hi[2], m_pre[2], m_pts[2], m_lvl[2];
    logic [41:0] m_seg[2];
    bit mvalid = 1'b0;

    function automatic int pow10(input int n);
        int p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    function automatic logic [6:0] pat(input int d);
        case (d)
            0: return 7'b1000000;  1: return 7'b1111001;
            2: return 7'b0100100;  3: return 7'b0110000;
            4: return 7'b0011001;  5: return 7'b0010010;
            6: return 7'b0000010;  7: return 7'b1111000;
            8: return 7'b0000000;  default: return 7'b0010000;
        endcase
    endfunction

    function automatic logic [23:0] to_bcd(input int v);
        logic [23:0] r = '0;
        for (int i = 0; i < 6; i++) r[4*i +: 4] = 4'((v / pow10(i)) % 10);
        return r;
    endfunction

    function automatic logic [41:0] enc(input int v, input int nd);
        logic [41:0] r = '0;
        for (int i = 0; i < nd; i++) begin
            if (i > 0 && v < pow10(i)) r[7*i +: 7] = 7'b1111111;
            else                       r[7*i +: 7] = pat((v / pow10(i)) % 10);
        end
        return r;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_state[k] = 0; m_score[k] = 0; m_hi[k] = 0;
                m_pre[k] = 0; m_pts[k] = 0; m_lvl[k] = 0;
                m_seg[k] = enc(0, ND[k]);
            end else begin
                m_seg[k] = enc(show_hi ? m_hi[k] : m_score[k], ND[k]);
                case (m_state[k])
                    0: if (start) begin
                        m_state[k] = 1; m_score[k] = 0; m_pre[k] = 0; m_pts[k] = 0;
                    end
                    1: if (collide) begin
                        m_state[k] = 2;
                    end else if (tick) begin
                        m_pre[k] = m_pre[k] + 1;
                        if (m_pre[k] == TPP[k]) begin
                            m_pre[k] = 0;
                            if (m_score[k] < pow10(ND[k]) - 1) begin
                                m_score[k] = m_score[k] + 1;
                                m_pts[k] = m_pts[k] + 1;
                                if (m_pts[k] == LP[k]) begin
                                    m_pts[k] = 0;
                                    if (m_lvl[k] < 15) m_lvl[k] = m_lvl[k] + 1;
                                end
                            end
                        end
                    end
                    default: begin
                        if (m_score[k] > m_hi[k]) m_hi[k] = m_score[k];
                        if (start && !collide) begin
                            m_state[k] = 1; m_score[k] = 0; m_pre[k] = 0;
                            m_pts[k] = 0; m_lvl[k] = 0;
                        end
                    end
                endcase
            end
        end
        if (rst) mvalid = 1'b1;
    end

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (mvalid) begin
            cmp("A.score", 64'(score_a), 64'(to_bcd(m_score[0])));
            cmp("A.hiscore", 64'(hi_a), 64'(to_bcd(m_hi[0])));
            cmp("A.level", 64'(level_a), 64'(m_lvl[0]));
            cmp("A.running", 64'(run_a), 64'(m_state[0] == 1));
            cmp("A.game_over", 64'(over_a), 64'(m_state[0] == 2));
            cmp("A.seg", 64'(seg_a), 64'(m_seg[0]));
            cmp("B.score", 64'(score_b), 64'(to_bcd(m_score[1])));
            cmp("B.hiscore", 64'(hi_b), 64'(to_bcd(m_hi[1])));
            cmp("B.level", 64'(level_b), 64'(m_lvl[1]));
            cmp("B.running", 64'(run_b), 64'(m_state[1] == 1));
            cmp("B.game_over", 64'(over_b), 64'(m_state[1] == 2));
            cmp("B.seg", 64'(seg_b), 64'(m_seg[1][13:0]));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input bit tk, input bit st, input bit col);
        @(negedge clk);
        #2;
        tick = tk; start = st; collide = col;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        // 1: reset, ticks without start do nothing
        rst = 1'b1;
        step(0, 0, 0); step(0, 0, 0);
        rst = 1'b0;
        ticks(10);
        idle();
        cmp("t1_score", 64'(score_a), 64'h0);
        cmp("t1_running", 64'(run_a), 64'h0);
        cmp("t1_seg_d0", 64'(seg_a[6:0]), 64'(7'b1000000));
        cmp("t1_seg_blank", 64'(seg_a[41:7]), 64'(35'h7_FFFF_FFFF));

        // 2: start, 8 ticks -> 2 points
        step(0, 1, 0);
        ticks(8);
        idle();
        cmp("t2_running", 64'(run_a), 64'h1);
        cmp("t2_score", 64'(score_a), 64'h000002);
        idle();
        cmp("t2_seg_d0", 64'(seg_a[6:0]), 64'(7'b0100100));

        // 4: collide with the 4th tick at score 5 wins over the increment
        rst = 1'b1;
        step(0, 0, 0);
        rst = 1'b0;
        step(0, 1, 0);
        ticks(23);
        step(1, 0, 1);
        idle();
        cmp("t4_over", 64'(over_a), 64'h1);
        cmp("t4_score", 64'(score_a), 64'h000005);
        cmp("t4_hi_not_yet", 64'(hi_a), 64'h0);
        idle();
        cmp("t4_hi", 64'(hi_a), 64'h000005);
        show_hi = 1'b1;
        idle();
        idle();
        cmp("t4_seg_hi", 64'(seg_a), 64'({35'h7_FFFF_FFFF, 7'b0010010}));
        show_hi = 1'b0;

        // 5: no restart into a collision; lower score keeps high score
        step(0, 1, 1);
        idle();
        cmp("t5_stay_over", 64'(over_a), 64'h1);
        step(0, 1, 0);
        idle();
        cmp("t5_running", 64'(run_a), 64'h1);
        cmp("t5_score0", 64'(score_a), 64'h0);
        cmp("t5_level0", 64'(level_a), 64'h0);
        cmp("t5_hi_kept", 64'(hi_a), 64'h000005);
        ticks(12);
        step(0, 0, 1);
        idle();
        idle();
        cmp("t5_score3", 64'(score_a), 64'h000003);
        cmp("t5_hi_still5", 64'(hi_a), 64'h000005);

        // 3 + 6: run to 100 (level 1); small instance saturates at 99 on the way
        step(0, 1, 0);
        ticks(400);
        idle();
        cmp("t3_score100", 64'(score_a), 64'h000100);
        cmp("t3_level1", 64'(level_a), 64'h1);
        cmp("t6_sat_score", 64'(score_b), 64'h99);
        cmp("t6_sat_level", 64'(level_b), 64'h9);
        idle();
        cmp("t3_seg", 64'(seg_a), 64'({21'h1F_FFFF, 7'b1111001, 7'b1000000, 7'b1000000}));
        ticks(8);
        idle();
        cmp("t6_hold_score", 64'(score_b), 64'h99);
        cmp("t6_hold_level", 64'(level_b), 64'h9);
        cmp("t6_a_score", 64'(score_a), 64'h000102);

        // reset mid-RUN
        rst = 1'b1;
        idle();
        rst = 1'b0;
        cmp("t6_rst_running", 64'(run_a), 64'h0);
        cmp("t6_rst_over", 64'(over_a), 64'h0);
        cmp("t6_rst_score", 64'(score_a), 64'h0);
        cmp("t6_rst_hi", 64'(hi_a), 64'h0);
        cmp("t6_rst_level", 64'(level_a), 64'h0);
        cmp("t6_rst_seg", 64'(seg_a), 64'({35'h7_FFFF_FFFF, 7'b1000000}));

        // randomized traffic, checked every cycle by the model
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            #2;
            rst     = ($urandom_range(0, 799) == 0);
            tick    = ($urandom_range(0, 1) == 1);
            start   = ($urandom_range(0, 15) == 0);
            collide = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 9) == 0) show_hi = ~show_hi;
        end
        rst = 1'b0;
        idle();
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
